// File: rtl/tqvp_stevej_wdt_kicker.sv
// tqvp_stevej_wdt_kicker
//
// Watchdog kicker peripheral for the TinyQV peripheral bus. This is the
// initiator end of a window-watchdog pat protocol. Once enabled, it counts
// PERIOD cycles and then emits a kick pulse that lasts PULSE cycles on the
// PMOD output. A period only ends in a kick if software has armed the kicker
// during that period. The watchdog expiry line is also monitored, and an
// interrupt is raised on a fault or on a missed arm.
//
// Optional feature macro: KICKER_LIVENESS_EN
//   defined   : kicks require an ARM write in each period; unarmed periods
//               set the missed flag instead of kicking.
//   undefined : armed is constant 1 and ARM writes are ignored; every period
//               ends in a kick and missed never sets.
//
// Ports:
//   clk            project clock
//   rst_n          asynchronous active-low reset
//   ui_in[7:0]     input PMOD (pre-synchronized); ui_in[1] = watchdog expired
//   uo_out[7:0]    {0, fault, missed, armed, enabled, kick_n, kick, 0}
//   address[5:0]   register select
//   data_in[31:0]  write data
//   data_write_n   2'b11 = idle, any other value = write
//   data_read_n    unused (reads are combinational)
//   data_out[31:0] read data for the selected address
//   data_ready     always 1
//   user_interrupt irq_en & (fault | missed)
//
// Register map:
//   0x0 CTRL   RW  bit0 enable, bit1 irq_en; any write restarts the FSM
//   0x1 PERIOD RW  32-bit period (0 acts as 1), locked while enabled
//   0x2 PULSE  RW  8-bit pulse width (0 acts as 1), locked while enabled
//   0x3 ARM    W   any write sets armed; reads {31'b0, armed}
//   0x4 STATUS R   {27'b0, fault, missed, armed, state}; W1C bit4/bit3
//   0x5 KICKS  R   saturating 16-bit kick count; any write clears it

module tqvp_stevej_wdt_kicker (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_PULSE = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] cnt;
  logic        kick;

  logic        enable;
  logic        irq_en;
  logic [31:0] period;
  logic [7:0]  pulse_w;

  logic        armed;
  logic        missed;
  logic        fault;
  logic [15:0] kicks;

  // Bus write decode. Only one address is written in any cycle.
  logic wr_en;
  logic wr_ctrl;
  logic wr_period;
  logic wr_pulse;
  logic wr_status;
  logic wr_kicks;

  assign wr_en     = (data_write_n != 2'b11);
  assign wr_ctrl   = wr_en && (address == 6'h0);
  assign wr_period = wr_en && (address == 6'h1);
  assign wr_pulse  = wr_en && (address == 6'h2);
  assign wr_status = wr_en && (address == 6'h4);
  assign wr_kicks  = wr_en && (address == 6'h5);

  // Last count of a period and of a pulse. A programmed 0 behaves as 1, so
  // both terminal counts collapse to 0 in that case.
  logic [31:0] p_last;
  logic [7:0]  w_last;

  assign p_last = (period  == 32'd0) ? 32'd0 : period  - 32'd1;
  assign w_last = (pulse_w == 8'd0)  ? 8'd0  : pulse_w - 8'd1;

  // The expiry line only matters while the kicker is actively running. A
  // CTRL write in the same cycle takes precedence and swallows it.
  logic fault_in;
  logic fault_take;

  assign fault_in   = ui_in[1] && ((state == S_COUNT) || (state == S_PULSE));
  assign fault_take = fault_in && !wr_ctrl;

  // End-of-period decision. It only happens when nothing with higher
  // priority (CTRL write, fault input) claims the cycle. The decision uses
  // the armed value from before this cycle's ARM write, so an ARM that lands
  // on the decision cycle counts toward the next period.
  logic period_end;
  logic decision_pulse;
  logic decision_miss;

  assign period_end     = !wr_ctrl && !fault_in && (state == S_COUNT) && (cnt == p_last);
  assign decision_pulse = period_end && armed;
  assign decision_miss  = period_end && !armed;

`ifdef KICKER_LIVENESS_EN
  logic wr_arm;
  logic armed_q;

  assign wr_arm = wr_en && (address == 6'h3);
  assign armed  = armed_q;

  // An ARM write always leaves armed set, even if the same cycle consumes
  // the previous arm for a kick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
    end else if (wr_arm) begin
      armed_q <= 1'b1;
    end else if (decision_pulse) begin
      armed_q <= 1'b0;
    end
  end
`else
  assign armed = 1'b1;
`endif

  // Configuration registers. PERIOD and PULSE are frozen while the kicker is
  // enabled, so the running timing cannot be disturbed mid-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable  <= 1'b0;
      irq_en  <= 1'b0;
      period  <= 32'd1000;
      pulse_w <= 8'd4;
    end else begin
      if (wr_ctrl) begin
        enable <= data_in[0];
        irq_en <= data_in[1];
      end
      if (wr_period && !enable) begin
        period <= data_in;
      end
      if (wr_pulse && !enable) begin
        pulse_w <= data_in[7:0];
      end
    end
  end

  // Main FSM. cnt counts through the period in COUNT and is reused as the
  // width counter in PULSE. The kick output is registered alongside the
  // state, so an asynchronous reset drops it immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 32'd0;
      kick  <= 1'b0;
    end else if (wr_ctrl) begin
      state <= data_in[0] ? S_COUNT : S_IDLE;
      cnt   <= 32'd0;
      kick  <= 1'b0;
    end else if (fault_in) begin
      state <= S_FAULT;
      cnt   <= 32'd0;
      kick  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt  <= 32'd0;
          kick <= 1'b0;
        end
        S_COUNT: begin
          if (cnt == p_last) begin
            cnt <= 32'd0;
            if (armed) begin
              state <= S_PULSE;
              kick  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_PULSE: begin
          if (cnt == {24'd0, w_last}) begin
            state <= S_COUNT;
            cnt   <= 32'd0;
            kick  <= 1'b0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_FAULT: begin
          kick <= 1'b0;
          if (wr_status && data_in[4] && enable) begin
            state <= S_COUNT;
            cnt   <= 32'd0;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= 32'd0;
          kick  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky status flags and the kick counter. A fault from the expiry line
  // wins over a same-cycle W1C of the fault bit. A W1C of missed wins over a
  // same-cycle miss, and a KICKS write wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault  <= 1'b0;
      missed <= 1'b0;
      kicks  <= 16'd0;
    end else begin
      if (fault_take) begin
        fault <= 1'b1;
      end else if (wr_status && data_in[4]) begin
        fault <= 1'b0;
      end

      if (wr_status && data_in[3]) begin
        missed <= 1'b0;
      end else if (decision_miss) begin
        missed <= 1'b1;
      end

      if (wr_kicks) begin
        kicks <= 16'd0;
      end else if (decision_pulse && (kicks != 16'hFFFF)) begin
        kicks <= kicks + 16'd1;
      end
    end
  end

  // Zero-wait read mux.
  always_comb begin
    data_out = 32'd0;
    case (address)
      6'h0:    data_out = {30'd0, irq_en, enable};
      6'h1:    data_out = period;
      6'h2:    data_out = {24'd0, pulse_w};
      6'h3:    data_out = {31'd0, armed};
      6'h4:    data_out = {27'd0, fault, missed, armed, state};
      6'h5:    data_out = {16'd0, kicks};
      default: data_out = 32'd0;
    endcase
  end

  assign uo_out         = {1'b0, fault, missed, armed, enable, ~kick, kick, 1'b0};
  assign data_ready     = 1'b1;
  assign user_interrupt = irq_en && (fault || missed);

  // Unused inputs are collected here so they are visibly accounted for.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, ui_in[7:2], ui_in[0], data_read_n};

endmodule

// File: tb/tb_tqvp_stevej_wdt_kicker.sv
// Self-checking bench for tqvp_stevej_wdt_kicker. Inputs are driven just
// after each falling edge and outputs are checked 1 ns later. After each
// rising edge, a reference model is stepped. The model tracks absolute cycle
// numbers for period and pulse boundaries, not a running counter. The bench
// follows whichever KICKER_LIVENESS_EN build it is compiled with.

module tb_tqvp_stevej_wdt_kicker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ui_in;
  logic [7:0]  uo_out;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  tqvp_stevej_wdt_kicker dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ui_in          (ui_in),
    .uo_out         (uo_out),
    .address        (address),
    .data_in        (data_in),
    .data_write_n   (data_write_n),
    .data_read_n    (data_read_n),
    .data_out       (data_out),
    .data_ready     (data_ready),
    .user_interrupt (user_interrupt)
  );

  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model state. The mode numbers match the architectural state
  // codes reported in STATUS.
  localparam int M_OFF  = 0;
  localparam int M_WAIT = 1;
  localparam int M_PAT  = 2;
  localparam int M_TRIP = 3;

  int          m_mode;
  longint      m_cyc;
  longint      m_mark;
  bit          m_enable;
  bit          m_irq;
  bit [31:0]   m_period;
  bit [7:0]    m_pulse;
  bit          m_armed;
  bit          m_missed;
  bit          m_fault;
  int          m_kicks;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks_total++;
    if (observed === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)",
               tag, observed, expected, m_cyc);
    end
  endtask

  function automatic bit armed_eff();
`ifdef KICKER_LIVENESS_EN
    return m_armed;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    m_mode   = M_OFF;
    m_mark   = 0;
    m_enable = 0;
    m_irq    = 0;
    m_period = 32'd1000;
    m_pulse  = 8'd4;
    m_armed  = 0;
    m_missed = 0;
    m_fault  = 0;
    m_kicks  = 0;
  endtask

  function automatic logic [7:0] exp_uo();
    bit k;
    k = (m_mode == M_PAT);
    return {1'b0, m_fault, m_missed, armed_eff(), m_enable, ~k, k, 1'b0};
  endfunction

  function automatic logic [31:0] exp_read(input logic [5:0] a);
    logic [1:0]  st;
    logic [15:0] kc;
    st = 2'(m_mode);
    kc = 16'(m_kicks);
    case (a)
      6'd0:    return {30'd0, m_irq, m_enable};
      6'd1:    return m_period;
      6'd2:    return {24'd0, m_pulse};
      6'd3:    return {31'd0, armed_eff()};
      6'd4:    return {27'd0, m_fault, m_missed, armed_eff(), st};
      6'd5:    return {16'd0, kc};
      default: return 32'd0;
    endcase
  endfunction

  // One rising edge of the reference model. A window that starts after edge
  // e ends at edge e+P (period) or e+W (pulse).
  task automatic model_edge(input bit wr, input logic [5:0] a,
                            input logic [31:0] d, input bit ui1);
    longint pe;
    longint we;
    bit     ctrl;
    bit     f_in;
    pe   = (m_period == 0) ? 1 : longint'(m_period);
    we   = (m_pulse == 0) ? 1 : longint'(m_pulse);
    ctrl = wr && (a == 6'd0);
    f_in = ui1 && (m_mode == M_WAIT || m_mode == M_PAT);
    if (ctrl) begin
      m_enable = d[0];
      m_irq    = d[1];
      m_mode   = d[0] ? M_WAIT : M_OFF;
      m_mark   = m_cyc;
    end else if (f_in) begin
      m_mode = M_TRIP;
    end else begin
      case (m_mode)
        M_WAIT: if (m_cyc == m_mark + pe) begin
          m_mark = m_cyc;
          if (armed_eff()) begin
            m_mode  = M_PAT;
            m_armed = 0;
            if (m_kicks < 65535) m_kicks++;
          end else begin
            m_missed = 1;
          end
        end
        M_PAT: if (m_cyc == m_mark + we) begin
          m_mode = M_WAIT;
          m_mark = m_cyc;
        end
        M_TRIP: if (wr && a == 6'd4 && d[4] && m_enable) begin
          m_mode = M_WAIT;
          m_mark = m_cyc;
        end
        default: ;
      endcase
    end
    if (wr && !ctrl) begin
      case (a)
        6'd1: if (!m_enable) m_period = d;
        6'd2: if (!m_enable) m_pulse = d[7:0];
`ifdef KICKER_LIVENESS_EN
        6'd3: m_armed = 1;
`endif
        6'd4: begin
          if (d[4]) m_fault = 0;
          if (d[3]) m_missed = 0;
        end
        6'd5: m_kicks = 0;
        default: ;
      endcase
    end
    if (f_in && !ctrl) m_fault = 1;
    m_cyc++;
  endtask

  // Drives one cycle of stimulus, checks the visible outputs, and then
  // advances the model across the following rising edge.
  task automatic applyStimulus(input bit wr, input logic [5:0] a,
                               input logic [31:0] d, input bit ui1);
    @(negedge clk);
    data_write_n = wr ? 2'($urandom_range(0, 2)) : 2'b11;
    address      = a;
    data_in      = d;
    data_read_n  = 2'($urandom);
    ui_in        = {6'($urandom), ui1, 1'($urandom)};
    #1;
    checkOutput("uo_out", {24'd0, uo_out}, {24'd0, exp_uo()});
    checkOutput("user_interrupt", {31'd0, user_interrupt},
                {31'd0, m_irq & (m_fault | m_missed)});
    checkOutput($sformatf("read_addr%0d", a), data_out, exp_read(a));
    checkOutput("data_ready", {31'd0, data_ready}, 32'd1);
    @(posedge clk);
    model_edge(wr, a, d, ui1);
  endtask

  // Runs idle/ARM cycles until the model is in a pulse. Returns 0 if no
  // pulse arrives within the budget.
  task automatic runUntilPulse(input int budget, output bit seen);
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      if (m_mode == M_PAT) begin
        seen = 1;
        break;
      end
      applyStimulus(1, 6'd3, 32'd0, 0);
    end
  endtask

  initial begin
    int          r;
    bit          ui1;
    logic [31:0] d;
    bit          seen;

    rst_n        = 1'b0;
    ui_in        = 8'd0;
    address      = 6'd0;
    data_in      = 32'd0;
    data_write_n = 2'b11;
    data_read_n  = 2'b11;
    m_cyc        = 0;
    model_reset();
    #3;
    checkOutput("reset_uo_out", {24'd0, uo_out}, {24'd0, exp_uo()});
    checkOutput("reset_irq", {31'd0, user_interrupt}, 32'd0);
    #9 rst_n = 1'b1;

    // Reset values of every register, with explicit constants for the
    // documented defaults.
    for (int a = 0; a < 6; a++) applyStimulus(0, 6'(a), 32'd0, 0);
    @(negedge clk);
    address = 6'd1;
    #1 checkOutput("reset_period", data_out, 32'd1000);
    address = 6'd2;
    #1 checkOutput("reset_pulse", data_out, 32'd4);
    address = 6'd4;
    #1 checkOutput("reset_status", data_out & 32'h1B, 32'd0);

    // PERIOD=10, PULSE=3, ARM, enable; then run two periods, the second one
    // without a new ARM.
    applyStimulus(1, 6'd1, 32'd10, 0);
    applyStimulus(1, 6'd2, 32'd3, 0);
    applyStimulus(1, 6'd3, 32'd0, 0);
    applyStimulus(1, 6'd0, 32'd3, 0);
    for (int i = 0; i < 30; i++) applyStimulus(0, 6'(i % 6), 32'd0, 0);
    applyStimulus(1, 6'd4, 32'h08, 0);
    applyStimulus(0, 6'd4, 32'd0, 0);

    // Expiry line in the middle of a pulse, then clear the fault with W1C.
    runUntilPulse(40, seen);
    checkOutput("pulse_seen_1", {31'd0, seen}, 32'd1);
    applyStimulus(0, 6'd4, 32'd0, 0);
    applyStimulus(0, 6'd4, 32'd0, 1);
    applyStimulus(0, 6'd4, 32'd0, 0);
    applyStimulus(1, 6'd4, 32'h10, 0);
    applyStimulus(1, 6'd1, 32'd77, 0);
    for (int i = 0; i < 14; i++) applyStimulus(0, 6'd1, 32'd0, 0);

    // PERIOD=0 and PULSE=0 behave as 1: a kick every 2 cycles.
    applyStimulus(1, 6'd0, 32'd0, 0);
    applyStimulus(1, 6'd1, 32'd0, 0);
    applyStimulus(1, 6'd2, 32'd0, 0);
    applyStimulus(1, 6'd0, 32'd1, 0);
    for (int i = 0; i < 12; i++) applyStimulus(1, 6'd3, 32'd0, 0);

    // Back to a short period, then random traffic.
    applyStimulus(1, 6'd0, 32'd0, 0);
    applyStimulus(1, 6'd1, 32'd5, 0);
    applyStimulus(1, 6'd2, 32'd1, 0);
    applyStimulus(1, 6'd0, 32'd3, 0);
    for (int i = 0; i < 3000; i++) begin
      r   = $urandom_range(0, 99);
      ui1 = ($urandom_range(0, 59) == 0);
      d   = $urandom;
      if (r < 70) begin
        applyStimulus(0, 6'($urandom_range(0, 7)), d, ui1);
      end else if (r < 74) begin
        d[0] = ($urandom_range(0, 9) != 0);
        applyStimulus(1, 6'd0, d, ui1);
      end else if (r < 78) begin
        if ($urandom_range(0, 19) != 0) d = $urandom_range(0, 12);
        applyStimulus(1, 6'd1, d, ui1);
      end else if (r < 81) begin
        d[7:0] = 8'($urandom_range(0, 5));
        applyStimulus(1, 6'd2, d, ui1);
      end else if (r < 90) begin
        applyStimulus(1, 6'd3, d, ui1);
      end else if (r < 96) begin
        applyStimulus(1, 6'd4, d, ui1);
      end else if (r < 98) begin
        applyStimulus(1, 6'd5, d, ui1);
      end else begin
        applyStimulus(1, 6'($urandom_range(6, 63)), d, ui1);
      end
    end

    // Asynchronous reset in the middle of a pulse.
    applyStimulus(1, 6'd0, 32'd0, 0);
    applyStimulus(1, 6'd1, 32'd6, 0);
    applyStimulus(1, 6'd2, 32'd4, 0);
    applyStimulus(1, 6'd4, 32'h18, 0);
    applyStimulus(1, 6'd0, 32'd1, 0);
    runUntilPulse(60, seen);
    checkOutput("pulse_seen_2", {31'd0, seen}, 32'd1);
    applyStimulus(0, 6'd5, 32'd0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checkOutput("async_reset_uo_out", {24'd0, uo_out}, {24'd0, exp_uo()});
    checkOutput("async_reset_kick", {31'd0, uo_out[1]}, 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/tqvp_stevej_wdt_kicker.md
# tqvp_stevej_wdt_kicker

Watchdog kicker peripheral for the TinyQV peripheral bus: the initiator end of the window-watchdog pat protocol. It emits periodic pat pulses on a PMOD output to drive an external window watchdog, and it pats only if software has proven liveness by arming it each period. It also monitors the watchdog's expiry line on `ui_in` and raises `user_interrupt` on a watchdog fault or a missed arm.

## Interface
- No parameters; all configuration is runtime via registers.
- `clk`  in  1  project clock, nominally 64 MHz
- `rst_n`  in  1  reset, asynchronous, active-low
- `ui_in`  in  8  input PMOD, already synchronized; `ui_in[1]` = external watchdog expired (active high)
- `uo_out`  out  8  {0, fault, missed, armed, enabled, kick_n, kick, 0} (bit 7 down to bit 0)
- `address`  in  6  register select
- `data_in`  in  32  write data
- `data_write_n`  in  2  11 = no write; any other value = write
- `data_read_n`  in  2  unused
- `data_out`  out  32  read data, combinational on `address`
- `data_ready`  out  1  constant 1
- `user_interrupt`  out  1  `irq_en & (fault | missed)`

## Operation
- 0x0 CTRL, RW: bit0 enable, bit1 irq_en.
  - Any write restarts the FSM: COUNT if enable=1, IDLE if enable=0; cnt cleared.
- 0x1 PERIOD, RW, 32 bit, reset 1000.
  - Writes are ignored while enabled; value 0 behaves as 1.
- 0x2 PULSE, RW, low 8 bits, reset 4.
  - Writes are ignored while enabled; value 0 behaves as 1.
- 0x3 ARM, W: any write sets `armed`. Reads return {31'b0, armed}.
- 0x4 STATUS, R: {27'b0, fault, missed, armed, state[1:0]}.
  - W1C on bit4 (fault) and bit3 (missed).
- 0x5 KICKS, R: 16-bit pulse count, saturates at 0xFFFF, cleared on write.
- Other addresses read 0.
- FSM states:
  - IDLE=0: kick=0, cnt held at 0.
  - COUNT=1: cnt increments each cycle. At cnt==P-1:
    - if armed: go to PULSE, clear armed, increment KICKS;
    - otherwise: set missed, reload cnt=0, stay in COUNT.
  - PULSE=2: kick=1 for W cycles, then COUNT with cnt=0.
  - FAULT=3: kick=0. Exit to COUNT on STATUS W1C of fault while enabled, or to IDLE on a CTRL write.
- Fault: `ui_in[1]`=1 in COUNT or PULSE gives FAULT next cycle and sets fault. `ui_in[1]` is ignored in IDLE.
- Priority, highest first: CTRL write, fault input, ARM/W1C, FSM counting.
- ARM write in the same cycle as the COUNT→PULSE decision:
  - the pulse is taken and armed ends at 1 (the new arm counts for the next period);
  - if armed was 0 at the decision, missed is set and armed ends at 1.

## Timing
- Reset values:
  - state=IDLE, cnt=0, enable=0, irq_en=0, armed=0, missed=0, fault=0, KICKS=0;
  - `uo_out`=0x04 (kick_n=1); `user_interrupt`=0; `data_ready`=1.
- CTRL enable write at clock edge T: state=COUNT from T+1.
- Kick rises at edge T+P and is high for exactly W cycles.
- With armed kept set, kicks repeat every P+W cycles.
- Register writes take effect at the next edge; reads are zero-wait.
- Fault input: FAULT and `user_interrupt` (if irq_en) are asserted one cycle after `ui_in[1]` is sampled high.
- An in-progress pulse is truncated at once (kick=0) on fault or CTRL write.
- Async reset mid-pulse: kick drops immediately, without waiting for a clock edge.
- cnt is 32 bit; it never wraps because it reloads at P-1.

## Configuration
- `KICKER_LIVENESS_EN`
  - Defined: pats require ARM as described above; missed is set on an unarmed period.
  - Undefined: armed reads as constant 1 and ARM writes are ignored; every period ends in PULSE; missed is never set.

## Test plan
- Reset, then read all registers → CTRL=0, PERIOD=1000, PULSE=4, STATUS=0, KICKS=0; `uo_out`=0x04.
- PERIOD=10, PULSE=3, ARM, CTRL=0x1 → kick high 3 cycles starting 10 cycles after the write; KICKS=1; armed=0.
- Same setup, no second ARM → no pulse on the second period; missed=1; with irq_en, `user_interrupt`=1; W1C bit3 clears it.
- Pulse in progress, drive `ui_in[1]`=1 → kick=0 and state=3 next cycle; fault=1. W1C bit4 → COUNT with cnt=0.
- PERIOD write while enabled → value unchanged. PERIOD=0, PULSE=0 → kick every 2 cycles, 1 cycle wide (ARM every period).
- Build without `KICKER_LIVENESS_EN`, PERIOD=5, PULSE=1 → kicks every 6 cycles with no ARM writes; missed stays 0.
